// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - line-granular memory responder with configurable grant and read latency
module line_mem_responder #(
    parameter int MEM_DEPTH = 16,
    parameter int GNT_LAT   = 1,
    parameter int RD_LAT    = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    output logic         gnt_o,
    input  logic         we_i,
    input  logic [31:0]  addr_i,
    input  logic [127:0] wdata_i,
    input  logic [15:0]  wstrb_i,
    output logic [127:0] rdata_o,
    output logic         rvalid_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] GNT_INIT = 4'(GNT_LAT - 1);
    localparam logic [3:0] RD_INIT  = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_WAIT, READ_WAIT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       mem_q [MEM_DEPTH];
    logic [127:0]       mem_d [MEM_DEPTH];
    logic [IDX_W-1:0]   req_idx;

    assign req_idx = addr_i[4+IDX_W-1:4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = 1'b0;
        idx_d   = idx_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = GRANT_WAIT;
                    cnt_d   = GNT_INIT;
                    gnt_d   = (GNT_INIT == 4'd0);
                end
            end
            GRANT_WAIT: begin
                // The grant is already on the wire, so the transaction is taken even if req_i drops now.
                if (gnt_q) begin
                    if (we_i) begin
                        for (int b = 0; b < 16; b++) begin
                            if (wstrb_i[b]) begin
                                mem_d[req_idx][8*b +: 8] = wdata_i[8*b +: 8];
                            end
                        end
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        idx_d   = req_idx;
                        cnt_d   = RD_INIT;
                        state_d = READ_WAIT;
                    end
                end else if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    gnt_d = (cnt_q == 4'd1);
                end
            end
            READ_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= 1'b0;
            idx_q   <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            mem_q   <= mem_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = (state_q == READ_WAIT) && (cnt_q == 4'd0);
    assign rdata_o  = rvalid_o ? mem_q[idx_q] : 128'd0;
endmodule
